mm_seg7_display: RTL
====================

// Module: mm_seg7_display
// PURPOSE
// - Display-side consumer of the multimeter result path: latches 4-digit BCD result
//   (din_bcd_i/din_update_i from result stage) and drives Basys3 4-digit common-anode
//   7-segment display. Time-multiplexed scan, anti-ghost blanking, decimal point,
//   optional leading-zero blanking, invalid-BCD detection. Outputs go straight to pins.
// PARAMETERS
// - CLK_HZ      100_000_000  system clock frequency
// - REFRESH_HZ  1000         per-digit slot rate; DIV = CLK_HZ/REFRESH_HZ cycles per slot
// - BLANK_CYC   64           cycles at start of each slot with all anodes off; must be < DIV
// - DP_POS      3            digit index lighting dp (3 = leftmost; default shows X.XXX V)
// - LZ_BLANK    1            1 = blank leading zeros on digits above DP_POS
// PORTS
// - clk           in   1   system clock
// - rst_n         in   1   asynchronous reset, active low
// - clr_i         in   1   sync clear of latched value
// - hold_i        in   1   1 = freeze display (ignore updates)
// - din_bcd_i     in   16  {thousands,hundreds,tens,units} BCD
// - din_update_i  in   1   1-cycle strobe, din_bcd_i valid
// - seg_o         out  7   {g,f,e,d,c,b,a}, active low
// - dp_o          out  1   decimal point, active low
// - an_o          out  4   anode enables, active low; an_o[0] = units (rightmost)
// - err_o         out  1   1 = latched value contains nibble > 9
// BEHAVIOUR
// - Reset: value reg 16'h0000, slot counter 0, digit index 0, seg_o 7'h7F, dp_o 1,
//   an_o 4'hF, err_o 0. All outputs registered.
// - Latch: clr_i -> value 0000 (priority over update). Else din_update_i & !hold_i ->
//   value <= din_bcd_i. Updates arriving while hold_i=1 are dropped (no pending).
//   New value visible on seg_o 2 cycles after strobe if its digit is active.
// - err_o registered from latched value: asserted 2 cycles after strobe of invalid data,
//   cleared likewise by a valid update or clr_i.
// - Scan: cnt runs 0..DIV-1, wraps. At cnt==DIV-1 digit index increments 0->1->2->3->0.
//   Single process; no other state. Index/cnt reset mid-scan restart at digit 0, cnt 0.
// - Output register (1-cycle latency from cnt/index): cnt<BLANK_CYC -> an_o=4'hF,
//   seg_o=7'h7F, dp_o=1; else an_o=~(4'b1<<idx), seg_o=enc(nibble[idx]), dp_o=~(idx==DP_POS).
// - enc active low: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//   6=0000010 7=1111000 8=0000000 9=0010000; nibble A-F -> dash 0111111.
// - Leading-zero blank (LZ_BLANK=1): digit k>DP_POS blanked (seg_o 7'h7F) when nibbles
//   k..3 all zero; anode still driven, timing unchanged. Digits <=DP_POS never blanked.
// - clr_i/hold_i do not affect scan timing.
// TESTING
// - Bench params: CLK_HZ=1000, REFRESH_HZ=100 (DIV=10), BLANK_CYC=2, DP_POS=3.
// - Reset asserted mid-scan -> seg_o 7'h7F, an_o 4'hF, dp_o 1, err_o 0; scan restarts digit 0.
// - Update 16'h1234 -> slots: an 1110 seg 0011001; 1101 seg 0110000; 1011 seg 0100100;
//   0111 seg 1111001 dp_o 0; each slot 2 cycles an 1111 then 8 cycles active; wraps to 0.
// - hold_i=1, update 16'h5678 -> still shows 1234; hold_i=0, update 16'h5678 -> shows 5678.
// - Update 16'h12A4 -> digit1 seg 0111111, err_o=1 two cycles after strobe; update 16'h0000
//   -> err_o=0.
// - clr_i and update 16'h9999 same cycle -> value 0000, all digits seg 1000000.
// - DP_POS=0, update 16'h0045 -> digits 3,2 seg 7F (anodes still scan), digit1 '4',
//   digit0 '5' with dp_o 0; 16'h0405 -> digit2 '4', digit3 blank.

Source files
------------

// File: rtl/mm_seg7_if.sv
// Result-path bus into the display: latched BCD value strobe plus clear/hold controls.
// The result stage drives through master; the display samples through slave.
interface mm_seg7_if;
  logic        clr_i;
  logic        hold_i;
  logic [15:0] din_bcd_i;
  logic        din_update_i;

  // din_update_i is a single-cycle strobe qualifying din_bcd_i.
  // There is no ready: the display is always able to take it, and drops it while hold_i is high.
  modport master (output clr_i, output hold_i, output din_bcd_i, output din_update_i);
  modport slave  (input  clr_i, input  hold_i, input  din_bcd_i, input  din_update_i);
endinterface

// File: rtl/mm_seg7_display.sv
// Basys3 4-digit common-anode 7-segment driver for the multimeter result.
// Latches a BCD value, scans the digits with anti-ghost blanking, and drives the pins from registers.
module mm_seg7_display #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_CYC  = 64,
  parameter int DP_POS     = 3,
  parameter int LZ_BLANK   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  mm_seg7_if.slave    bus,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        err_o
);
  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [1:0]    DP_IDX    = 2'(DP_POS);

  logic [15:0]   value;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic [3:0]    lz_blank;
  logic          upper_zero;
  logic          err_n;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b0111111;
    endcase
  endfunction

  // Clear wins over an update in the same cycle; held updates are simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 16'h0000;
    end else if (bus.clr_i) begin
      value <= 16'h0000;
    end else if (bus.din_update_i && !bus.hold_i) begin
      value <= bus.din_bcd_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Walk from the most significant digit down; a digit left of the decimal point
  // is blanked only while it and everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = 4'b0000;
    err_n      = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      upper_zero  = upper_zero & (value[4*k +: 4] == 4'h0);
      lz_blank[k] = (LZ_BLANK != 0) && (k > DP_POS) && upper_zero;
      err_n       = err_n | (value[4*k +: 4] > 4'd9);
    end
  end

  assign nib = value[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= 7'h7F;
      dp_o  <= 1'b1;
      an_o  <= 4'hF;
      err_o <= 1'b0;
    end else begin
      err_o <= err_n;
      if (cnt < BLANK_END) begin
        seg_o <= 7'h7F;
        dp_o  <= 1'b1;
        an_o  <= 4'hF;
      end else begin
        seg_o <= lz_blank[idx] ? 7'h7F : enc(nib);
        dp_o  <= ~(idx == DP_IDX);
        an_o  <= ~(4'b0001 << idx);
      end
    end
  end
endmodule
